// File: rtl/scan_sel4.sv
// scan_sel4 -- select sequencer for a downstream 4:1 mux and its one-hot
// active-low enable word (e.g. 7-segment anodes).
//
// The select advances on a prescaled tick (auto up/down), on a synchronized
// pushbutton rising edge (manual step, always up), or by a direct load.
// Per-edge priority is rst > load > advance.
//
// Build option: define STEP_DEBOUNCE_EN to insert a DEB_CNT-cycle stability
// filter between the step synchronizer and the edge detector. Without it the
// step path is a plain 3-register synchronizer/edge detector and DEB_CNT is
// only range-checked.
//
// The prescaler is a down-counter reloaded with DIV-1. Its terminal count (0)
// is the advance point. "Prescaler cleared" therefore means reloaded.

module scan_sel4 #(
   parameter int DIV     = 50000,
   parameter int DEB_CNT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       step,
   input  logic       load,
   input  logic [1:0] load_val,
   output logic [1:0] s,
   output logic [3:0] an,
   output logic       tick,
   output logic       wrap
);

   localparam logic [1:0]  MODE_HOLD = 2'b00;
   localparam logic [1:0]  MODE_UP   = 2'b01;
   localparam logic [1:0]  MODE_DOWN = 2'b10;
   localparam logic [1:0]  MODE_STEP = 2'b11;
   localparam logic [19:0] PRESC_TOP = 20'(DIV - 1);

   // Reject out-of-range configurations at elaboration.
   if (DIV < 1 || DIV > 1048576) begin : g_bad_div
      $error("scan_sel4: DIV out of range 1..2^20");
   end
   if (DEB_CNT < 1 || DEB_CNT > 255) begin : g_bad_deb
      $error("scan_sel4: DEB_CNT out of range 1..255");
   end

   function automatic logic [3:0] an_of(input logic [1:0] sel);
      return ~(4'b0001 << sel);
   endfunction

   logic        sync1;
   logic        sync2;
   logic        sync3;
   logic        edge_q;
   logic [1:0]  mode_q;
   logic [19:0] presc_rem;

   logic        mode_chg;
   logic        auto_mode;
   logic        presc_tc;
   logic        auto_adv;
   logic        step_adv;
   logic        adv_up;
   logic [1:0]  s_adv;

   // Two-flop synchronizer for the asynchronous pushbutton.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= step;
         sync2 <= sync1;
      end
   end

`ifdef STEP_DEBOUNCE_EN
   localparam logic [7:0] DEB_TOP = 8'(DEB_CNT - 1);

   logic       deb_lvl;
   logic [7:0] deb_rem;

   // Debounced level follows sync2 only after DEB_CNT consecutive mismatching
   // cycles; any return to the current level reloads the timer. sync3 holds
   // the previous debounced level so the edge is taken on the filtered signal.
   always_ff @(posedge clk) begin
      if (rst) begin
         deb_lvl <= 1'b0;
         deb_rem <= DEB_TOP;
         sync3   <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         if (sync2 == deb_lvl) begin
            deb_rem <= DEB_TOP;
         end else if (deb_rem == 8'd0) begin
            deb_lvl <= sync2;
            deb_rem <= DEB_TOP;
         end else begin
            deb_rem <= deb_rem - 8'd1;
         end
         sync3  <= deb_lvl;
         edge_q <= deb_lvl & ~sync3;
      end
   end
`else
   // Third register and registered rising-edge detect; edge_q is acted on one
   // edge later, giving a fixed 3-edge latency from the first high sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync3  <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         sync3  <= sync2;
         edge_q <= sync2 & ~sync3;
      end
   end
`endif

   // Advance qualification; a mode change suppresses any advance on that edge.
   always_comb begin
      mode_chg  = (mode != mode_q);
      auto_mode = (mode == MODE_UP) || (mode == MODE_DOWN);
      presc_tc  = (presc_rem == 20'd0);
      auto_adv  = en & auto_mode & ~mode_chg & presc_tc;
      step_adv  = en & (mode == MODE_STEP) & ~mode_chg & edge_q;
      adv_up    = (mode != MODE_DOWN);
      s_adv     = adv_up ? (s + 2'd1) : (s - 2'd1);
   end

   // Previous-cycle mode; tracked through reset so the first edge after
   // release is not mistaken for a mode change.
   always_ff @(posedge clk) begin
      mode_q <= mode;
   end

   // Select, anode word, pulses and prescaler; load beats advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         s         <= 2'd0;
         an        <= 4'b1110;
         tick      <= 1'b0;
         wrap      <= 1'b0;
         presc_rem <= PRESC_TOP;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         if (load) begin
            s         <= load_val;
            an        <= an_of(load_val);
            tick      <= 1'b1;
            presc_rem <= PRESC_TOP;
         end else begin
            if (mode_chg || !auto_mode || (mode == MODE_HOLD)) begin
               presc_rem <= PRESC_TOP;
            end else if (en) begin
               presc_rem <= presc_tc ? PRESC_TOP : (presc_rem - 20'd1);
            end
            if (auto_adv || step_adv) begin
               s    <= s_adv;
               an   <= an_of(s_adv);
               tick <= 1'b1;
               wrap <= adv_up ? (s == 2'd3) : (s == 2'd0);
            end
         end
      end
   end

endmodule

// File: tb/tb_scan_sel4.sv
// Testbench for scan_sel4: two instances (DIV=4 and DIV=1) share all inputs
// and are compared every cycle against a cycle-level reference model built
// from the behavioural rules (sample history for the step path, integer
// up-counter for the prescaler, modular arithmetic for the select).

module tb_scan_sel4;

   localparam int DEB = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic       step;
   logic       load;
   logic [1:0] load_val;

   logic [1:0] s_a, s_b;
   logic [3:0] an_a, an_b;
   logic       tick_a, tick_b, wrap_a, wrap_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   scan_sel4 #(.DIV(4), .DEB_CNT(DEB)) dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step),
      .load(load), .load_val(load_val),
      .s(s_a), .an(an_a), .tick(tick_a), .wrap(wrap_a)
   );

   scan_sel4 #(.DIV(1), .DEB_CNT(DEB)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step),
      .load(load), .load_val(load_val),
      .s(s_b), .an(an_b), .tick(tick_b), .wrap(wrap_b)
   );

   typedef struct {
      logic [1:0] s;
      int         cnt;
      logic [1:0] mp;
      logic [3:0] h;     // step samples: [0]=last edge .. [3]=four edges ago
      logic [2:0] dlh;   // debounced level history, same ordering
      logic       dl;
      int         run;
      logic       tick;
      logic       wrap;
   } mstate_t;

   mstate_t ma, mb;

   function automatic mstate_t mstep(input mstate_t m, input int div);
      mstate_t n = m;
      logic    act;
      logic    chg;
      logic    do_adv = 1'b0;
      logic    up = 1'b1;
      chg  = (mode != m.mp);
      n.mp = mode;
      if (rst) begin
         n.s = 2'd0; n.cnt = 0; n.h = 4'd0; n.dlh = 3'd0; n.dl = 1'b0;
         n.run = 0; n.tick = 1'b0; n.wrap = 1'b0;
         return n;
      end
`ifdef STEP_DEBOUNCE_EN
      act = m.dlh[1] & ~m.dlh[2];
      if (m.h[1] != m.dl) begin
         n.run = m.run + 1;
         if (n.run == DEB) begin
            n.dl  = m.h[1];
            n.run = 0;
         end
      end else begin
         n.run = 0;
      end
      n.dlh = {m.dlh[1:0], n.dl};
`else
      act = m.h[2] & ~m.h[3];
`endif
      n.h    = {m.h[2:0], step};
      n.tick = 1'b0;
      n.wrap = 1'b0;
      if (load) begin
         n.s    = load_val;
         n.cnt  = 0;
         n.tick = 1'b1;
      end else if (chg) begin
         n.cnt = 0;
      end else if (en) begin
         if (mode == 2'd1 || mode == 2'd2) begin
            if (m.cnt == div - 1) begin
               n.cnt  = 0;
               do_adv = 1'b1;
               up     = (mode == 2'd1);
            end else begin
               n.cnt = m.cnt + 1;
            end
         end else if (mode == 2'd3 && act) begin
            do_adv = 1'b1;
         end
      end
      if (do_adv) begin
         n.s    = 2'((int'(m.s) + (up ? 1 : 3)) % 4);
         n.wrap = up ? (m.s == 2'd3) : (m.s == 2'd0);
         n.tick = 1'b1;
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] an_exp(input logic [1:0] sel);
      logic [3:0] w = 4'b1111;
      w[sel] = 1'b0;
      return w;
   endfunction

   task automatic cycle();
      @(posedge clk);
      ma = mstep(ma, 4);
      mb = mstep(mb, 1);
      #1;
      chk("s_div4",    {2'b00, s_a},     {2'b00, ma.s});
      chk("an_div4",   an_a,             an_exp(ma.s));
      chk("tick_div4", {3'b000, tick_a}, {3'b000, ma.tick});
      chk("wrap_div4", {3'b000, wrap_a}, {3'b000, ma.wrap});
      chk("s_div1",    {2'b00, s_b},     {2'b00, mb.s});
      chk("an_div1",   an_b,             an_exp(mb.s));
      chk("tick_div1", {3'b000, tick_b}, {3'b000, mb.tick});
      chk("wrap_div1", {3'b000, wrap_b}, {3'b000, mb.wrap});
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; mode = 2'b01; step = 1'b0;
      load = 1'b0; load_val = 2'd0;

      // reset held two cycles while in auto-up
      cycle();
      cycle();
      rst = 1'b0;

      // auto up: 1,2,3,0 every 4 edges on the DIV=4 unit
      repeat (16) cycle();

      // auto down from 0, with a 10-cycle freeze mid-count
      load = 1'b1; load_val = 2'd0; cycle(); load = 1'b0;
      mode = 2'b10;
      repeat (6) cycle();
      en = 1'b0;
      repeat (10) cycle();
      en = 1'b1;
      repeat (12) cycle();

      // load on the same edge as a prescaler rollover
      mode = 2'b01;
      cycle();
      for (int i = 0; i < 8; i++) begin
         if (ma.cnt == 3) break;
         cycle();
      end
      load = 1'b1; load_val = 2'd2; cycle(); load = 1'b0;
      repeat (8) cycle();

      // manual step: single pulse, long hold, and step ignored in auto mode
      mode = 2'b11;
      repeat (3) cycle();
      step = 1'b1; cycle(); step = 1'b0;
      repeat (6) cycle();
      step = 1'b1; repeat (20) cycle(); step = 1'b0;
      repeat (6) cycle();
      mode = 2'b01;
      repeat (2) cycle();
      step = 1'b1; repeat (3) cycle(); step = 1'b0;
      repeat (8) cycle();

      // hold mode keeps s
      mode = 2'b00;
      repeat (10) cycle();

`ifdef STEP_DEBOUNCE_EN
      // bouncing step never settles, then a clean press
      mode = 2'b11;
      repeat (3) cycle();
      for (int i = 0; i < 10; i++) begin
         step = ~step;
         repeat (3) cycle();
      end
      step = 1'b0;
      repeat (12) cycle();
      step = 1'b1;
      repeat (16) cycle();
      step = 1'b0;
      repeat (16) cycle();
`endif

      // randomized traffic
      repeat (3000) begin
         rst      = ($urandom % 200) == 0;
         load     = ($urandom % 30) == 0;
         load_val = 2'($urandom);
         en       = ($urandom % 8) != 0;
         if (($urandom % 20) == 0) mode = 2'($urandom);
         if (($urandom % 5) == 0) step = ~step;
         cycle();
      end
      rst = 1'b0; load = 1'b0;
      repeat (4) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
